// File: rtl/join_result_packer.sv
// Packs hash-join probe results into 4-slot output lines.
// Emits full lines, then one final (possibly empty) line with m_last.
module join_result_packer #(
  parameter bit DROP_UNJOINED = 1'b1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [63:0]  in_serialnum,
  input  logic         in_was_joined,
  input  logic         in_last_processed,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [511:0] m_data,
  output logic [3:0]   m_keep,
  output logic [63:0]  m_first_serial,
  output logic         m_last,
  output logic [63:0]  joined_count,
  output logic [63:0]  probed_count,
  output logic         done
);

  typedef enum logic [1:0] {
    COLLECT,
    EMIT,
    FLUSH,
    DONE
  } state_t;

  state_t     state;
  logic [1:0] fill_cnt;
  logic       store;

  assign store = in_was_joined | ~DROP_UNJOINED;

  // Packer FSM: slots are written in place so every output is a flop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= COLLECT;
      in_ready       <= 1'b1;
      m_valid        <= 1'b0;
      m_data         <= '0;
      m_keep         <= '0;
      m_first_serial <= '0;
      m_last         <= 1'b0;
      joined_count   <= '0;
      probed_count   <= '0;
      done           <= 1'b0;
      fill_cnt       <= '0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (in_valid) begin
            probed_count <= probed_count + 64'd1;
            if (in_was_joined)
              joined_count <= joined_count + 64'd1;
            if (store) begin
              m_data[{fill_cnt, 7'd0} +: 128] <= in_data;
              m_keep[fill_cnt] <= 1'b1;
              if (fill_cnt == 2'd0)
                m_first_serial <= in_serialnum;
              fill_cnt <= fill_cnt + 2'd1;
              if (fill_cnt == 2'd3) begin
                state    <= EMIT;
                in_ready <= 1'b0;
                m_valid  <= 1'b1;
                m_last   <= 1'b0;
              end
            end
          end else if (in_last_processed) begin
            state    <= FLUSH;
            in_ready <= 1'b0;
            m_valid  <= 1'b1;
            m_last   <= 1'b1;
          end
        end
        EMIT: begin
          if (m_ready) begin
            state          <= COLLECT;
            in_ready       <= 1'b1;
            m_valid        <= 1'b0;
            m_data         <= '0;
            m_keep         <= '0;
            m_first_serial <= '0;
            fill_cnt       <= '0;
          end
        end
        FLUSH: begin
          if (m_ready) begin
            state   <= DONE;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_join_result_packer.sv
// Directed bench for join_result_packer.
// Two instances cover both DROP_UNJOINED settings.
module tb_join_result_packer;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid;
  logic [127:0] in_data;
  logic [63:0]  in_serialnum;
  logic         in_was_joined;
  logic         in_last_processed;
  logic         m_ready;

  logic         in_ready, m_valid, m_last, done;
  logic [511:0] m_data;
  logic [3:0]   m_keep;
  logic [63:0]  m_first_serial, joined_count, probed_count;

  logic         in_ready0, m_valid0, m_last0, done0;
  logic [511:0] m_data0;
  logic [3:0]   m_keep0;
  logic [63:0]  m_first_serial0, joined_count0, probed_count0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  join_result_packer u_dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_serialnum(in_serialnum),
    .in_was_joined(in_was_joined),
    .in_last_processed(in_last_processed),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep),
    .m_first_serial(m_first_serial), .m_last(m_last),
    .joined_count(joined_count), .probed_count(probed_count),
    .done(done)
  );

  join_result_packer #(.DROP_UNJOINED(1'b0)) u_dut0 (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_serialnum(in_serialnum),
    .in_was_joined(in_was_joined),
    .in_last_processed(in_last_processed),
    .m_valid(m_valid0), .m_ready(m_ready),
    .m_data(m_data0), .m_keep(m_keep0),
    .m_first_serial(m_first_serial0), .m_last(m_last0),
    .joined_count(joined_count0), .probed_count(probed_count0),
    .done(done0)
  );

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int k);
    mk = {64'hB000 + 64'(k), 64'hA000 + 64'(k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    in_valid = 1'b0;
    in_last_processed = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic send(input int k, input logic [63:0] sn,
                      input logic j);
    in_valid = 1'b1;
    in_data = mk(k);
    in_serialnum = sn;
    in_was_joined = j;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (m_valid) break;
      tick();
    end
    chk(tag, 512'(m_valid), 512'd1);
  endtask

  logic [511:0] line;

  initial begin
    resetn = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_serialnum = '0;
    in_was_joined = 1'b0;
    in_last_processed = 1'b0;
    m_ready = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    chk("rst_valid", 512'(m_valid), 512'd0);
    chk("rst_keep", 512'(m_keep), 512'd0);
    chk("rst_data", m_data, 512'd0);
    chk("rst_probed", 512'(probed_count), 512'd0);
    chk("rst_done", 512'(done), 512'd0);
    chk("rst_ready", 512'(in_ready), 512'd1);

    // four joined results, serials 10..13
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(k, 64'(10 + k), 1'b1);
    line = {mk(3), mk(2), mk(1), mk(0)};
    chk("t42_valid", 512'(m_valid), 512'd1);
    chk("t42_keep", 512'(m_keep), 512'hF);
    chk("t42_first", 512'(m_first_serial), 512'd10);
    chk("t42_data", m_data, line);
    chk("t42_last", 512'(m_last), 512'd0);
    chk("t42_joined", 512'(joined_count), 512'd4);
    chk("t42_rdy", 512'(in_ready), 512'd0);
    tick();
    chk("t42_drain", 512'(m_valid), 512'd0);
    chk("t42_clear", m_data, 512'd0);

    // drop pattern 1,0,1,0,1,1 then last
    do_reset();
    m_ready = 1'b1;
    send(0, 64'd1, 1'b1);
    send(1, 64'd2, 1'b0);
    send(2, 64'd3, 1'b1);
    send(3, 64'd4, 1'b0);
    send(4, 64'd5, 1'b1);
    send(5, 64'd6, 1'b1);
    wait_valid("t43_full_v");
    chk("t43_keep", 512'(m_keep), 512'hF);
    chk("t43_data", m_data, {mk(5), mk(4), mk(2), mk(0)});
    chk("t43_first", 512'(m_first_serial), 512'd1);
    in_last_processed = 1'b1;
    tick();
    chk("t43_gap", 512'(m_valid), 512'd0);
    wait_valid("t43_fin_v");
    chk("t43_fkeep", 512'(m_keep), 512'h0);
    chk("t43_flast", 512'(m_last), 512'd1);
    chk("t43_fdata", m_data, 512'd0);
    chk("t43_fser", 512'(m_first_serial), 512'd0);
    chk("t43_probed", 512'(probed_count), 512'd6);
    chk("t43_joined", 512'(joined_count), 512'd4);
    tick();
    chk("t43_done", 512'(done), 512'd1);
    chk("t43_dvalid", 512'(m_valid), 512'd0);
    chk("t43_drdy", 512'(in_ready), 512'd0);
    in_valid = 1'b1;
    in_was_joined = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t43_frozen", 512'(probed_count), 512'd6);

    // partial flush with backpressure
    do_reset();
    m_ready = 1'b0;
    send(0, 64'd20, 1'b1);
    send(1, 64'd21, 1'b1);
    in_last_processed = 1'b1;
    wait_valid("t44_v");
    line = {256'd0, mk(1), mk(0)};
    for (int c = 0; c < 5; c++) begin
      chk("t44_hold_v", 512'(m_valid), 512'd1);
      chk("t44_hold_d", m_data, line);
      chk("t44_rdy", 512'(in_ready), 512'd0);
      tick();
    end
    chk("t44_keep", 512'(m_keep), 512'h3);
    chk("t44_last", 512'(m_last), 512'd1);
    chk("t44_first", 512'(m_first_serial), 512'd20);
    chk("t44_nodone", 512'(done), 512'd0);
    m_ready = 1'b1;
    tick();
    chk("t44_done", 512'(done), 512'd1);
    chk("t44_v0", 512'(m_valid), 512'd0);
    chk("t44_l0", 512'(m_last), 512'd0);

    // last asserted alongside the fourth joined result
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) send(k, 64'(30 + k), 1'b1);
    in_last_processed = 1'b1;
    send(3, 64'd33, 1'b1);
    chk("t45_ev", 512'(m_valid), 512'd1);
    chk("t45_ekeep", 512'(m_keep), 512'hF);
    chk("t45_elast", 512'(m_last), 512'd0);
    tick();
    chk("t45_gap", 512'(m_valid), 512'd0);
    wait_valid("t45_fv");
    chk("t45_fkeep", 512'(m_keep), 512'h0);
    chk("t45_flast", 512'(m_last), 512'd1);

    // reset with a partial buffer
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) send(k, 64'(60 + k), 1'b1);
    chk("t46_novalid", 512'(m_valid), 512'd0);
    chk("t46_pkeep", 512'(m_keep), 512'h7);
    do_reset();
    chk("t46_v", 512'(m_valid), 512'd0);
    chk("t46_keep", 512'(m_keep), 512'h0);
    chk("t46_data", m_data, 512'd0);
    chk("t46_first", 512'(m_first_serial), 512'd0);
    chk("t46_cnt", 512'(joined_count), 512'd0);
    chk("t46_rdy", 512'(in_ready), 512'd1);
    for (int k = 0; k < 4; k++) send(k + 8, 64'(40 + k), 1'b1);
    chk("t46_nv", 512'(m_valid), 512'd1);
    chk("t46_nfirst", 512'(m_first_serial), 512'd40);
    chk("t46_ndata", m_data, {mk(11), mk(10), mk(9), mk(8)});

    // keep-all instance with unjoined results
    do_reset();
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(k, 64'(50 + k), 1'b0);
    chk("t47_v", 512'(m_valid0), 512'd1);
    chk("t47_keep", 512'(m_keep0), 512'hF);
    chk("t47_data", m_data0, {mk(3), mk(2), mk(1), mk(0)});
    chk("t47_first", 512'(m_first_serial0), 512'd50);
    chk("t47_joined", 512'(joined_count0), 512'd0);
    chk("t47_probed", 512'(probed_count0), 512'd4);
    chk("t47_dkeep", 512'(m_keep), 512'h0);
    chk("t47_dprobed", 512'(probed_count), 512'd4);
    chk("t47_dv", 512'(m_valid), 512'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/join_result_packer.md
JOIN_RESULT_PACKER -- requirements
Module: join_result_packer

Interface
REQ-001 Parameter: DROP_UNJOINED, default 1, meaning 1 = discard results with in_was_joined=0 and 0 = pack every result.
REQ-002 clk  input  1  single clock; all logic on posedge.
REQ-003 resetn  input  1  reset; synchronous, active-low.
REQ-004 in_valid  input  1  probe-result valid, driven by the hash table out_valid.
REQ-005 in_ready  output  1  packer can accept a result this cycle.
REQ-006 in_data  input  128  joined pair: [127:64] build tuple, [63:0] probe tuple.
REQ-007 in_serialnum  input  64  serial number of the probe tuple.
REQ-008 in_was_joined  input  1  result is a match.
REQ-009 in_last_processed  input  1  level; probe stream exhausted.
REQ-010 m_valid  output  1  packed line valid.
REQ-011 m_ready  input  1  downstream accepts the line.
REQ-012 m_data  output  512  4 result slots; slot k occupies [k*128 +: 128].
REQ-013 m_keep  output  4  bit k=1 means slot k holds a result.
REQ-014 m_first_serial  output  64  in_serialnum of slot 0 (0 if slot 0 is empty).
REQ-015 m_last  output  1  final line of the stream.
REQ-016 joined_count  output  64  accepted results with in_was_joined=1.
REQ-017 probed_count  output  64  all accepted results.
REQ-018 done  output  1  final line has been transferred.

Function
REQ-019 States SHALL be COLLECT, EMIT, FLUSH and DONE.
REQ-020 An input transfer SHALL occur when in_valid=1 and in_ready=1 on the same posedge.
REQ-021 in_ready SHALL be 1 only in COLLECT.
REQ-022 Each transfer SHALL increment probed_count by 1.
REQ-023 Each transfer with in_was_joined=1 SHALL also increment joined_count by 1.
REQ-024 Both counters SHALL wrap modulo 2^64.
REQ-025 A transfer SHALL be stored when in_was_joined=1 or DROP_UNJOINED=0: in_data goes to slot fill_cnt, m_keep[fill_cnt] is set, and fill_cnt increments. All other transfers SHALL be counted but not stored.
REQ-026 The store that fills slot 3 SHALL move COLLECT->EMIT, with m_valid=1 on the next cycle (1-cycle latency) and m_last=0.
REQ-027 In EMIT, m_valid, m_data, m_keep and m_first_serial SHALL hold stable until m_ready=1. At that edge: clear the slots, m_keep and fill_cnt, drive m_valid to 0, and return to COLLECT.
REQ-028 In COLLECT, in_last_processed=1 with in_valid=0 SHALL move the block to FLUSH. Next cycle: m_valid=1, m_last=1, and the current partial m_keep, which may be 4'b0000.
REQ-029 In COLLECT, in_last_processed=1 with in_valid=1 SHALL take the transfer only; the flush decision waits for a cycle with in_valid=0.
REQ-030 If the transfer in REQ-029 fills slot 3, EMIT SHALL be taken first. The next COLLECT cycle then flushes with m_keep=4'b0000.
REQ-031 FLUSH SHALL hold outputs until m_ready=1, then move to DONE with m_valid=0 and m_last=0.
REQ-032 done SHALL be set when the block enters DONE.
REQ-033 DONE SHALL be terminal until reset: in_ready=0, m_valid=0, and the counters frozen.
REQ-034 Unused slots SHALL read 0.
REQ-035 Slots SHALL fill in arrival order, starting at slot 0.
REQ-036 All outputs SHALL be registered, with no combinational path from in_* to m_*.
REQ-037 in_ready SHALL depend on state only.

Reset
REQ-038 When resetn=0 at a posedge, the block SHALL enter COLLECT.
REQ-039 Reset SHALL clear: m_valid, m_data, m_keep, m_first_serial, m_last, joined_count, probed_count, done, fill_cnt.
REQ-040 Reset SHALL hold in_ready=1 from the first cycle after reset.
REQ-041 Reset during EMIT, FLUSH or with a partial buffer SHALL discard buffered results without emitting them.

Verification
REQ-042 Four joined results, serials 10..13, m_ready=1 -> one line with m_keep=1111, m_first_serial=10, slots in order, m_last=0; joined_count=4.
REQ-043 DROP_UNJOINED=1, 6 results with was_joined pattern 1,0,1,0,1,1, then last -> one full line (m_keep=1111), then a final line with m_keep=0000, m_last=1; probed_count=6, joined_count=4, done=1.
REQ-044 Two joined results then last, m_ready held 0 for 5 cycles -> m_valid=1 with data stable throughout, m_keep=0011, m_last=1; in_ready=0 during FLUSH; done=1 one cycle after m_ready rises.
REQ-045 in_valid=1 and in_last_processed=1 together on the 4th joined result -> EMIT line with m_keep=1111, m_last=0, then a FLUSH line with m_keep=0000, m_last=1.
REQ-046 resetn=0 with 3 slots filled and m_valid=0 -> no line emitted; all outputs 0, in_ready=1 next cycle; next 4 results produce a fresh line with m_first_serial equal to the first serial after reset.
REQ-047 DROP_UNJOINED=0, 4 unjoined results -> m_keep=1111, joined_count=0, probed_count=4.
